// File: rtl/bank_mapper_pkg.sv
// Shared constants for the bank mapper: gate-array function codes,
// RAM configuration encodings and register reset values.
package bank_mapper_pkg;

   localparam logic [1:0] GA_FN_ROM = 2'b10;
   localparam logic [1:0] GA_FN_RAM = 2'b11;

   typedef logic [2:0] ram_cfg_t;

   localparam ram_cfg_t RAM_CFG_BASE    = 3'd0;
   localparam ram_cfg_t RAM_CFG_HI_EXT  = 3'd1;
   localparam ram_cfg_t RAM_CFG_ALL_EXT = 3'd2;
   localparam ram_cfg_t RAM_CFG_HI_SWAP = 3'd3;

   localparam logic     LROM_EN_RST = 1'b1;
   localparam logic     HROM_EN_RST = 1'b1;
   localparam ram_cfg_t RAM_CFG_RST = RAM_CFG_BASE;

endpackage

// File: rtl/bank_mapper_ram_map.sv
// Combinational RAM page mapping: (cfg, bank, block) -> expansion flag,
// expansion bank and 16 KB block.
module bank_mapper_ram_map
   import bank_mapper_pkg::*;
#(
   parameter int unsigned RAM_BANK_BITS = 3
) (
   input  logic [2:0]               cfg_i,
   input  logic [RAM_BANK_BITS-1:0] bank_i,
   input  logic [1:0]               blk_i,
   output logic                     ext_o,
   output logic [RAM_BANK_BITS-1:0] bank_o,
   output logic [1:0]               blk_o
);

   always_comb begin
      ext_o = 1'b0;
      blk_o = blk_i;
      if (cfg_i[2]) begin
         // cfg 4..7 open one expansion block in the &4000 window
         if (blk_i == 2'd1) begin
            ext_o = 1'b1;
            blk_o = cfg_i[1:0];
         end
      end else begin
         unique case (cfg_i)
            RAM_CFG_HI_EXT:  ext_o = (blk_i == 2'd3);
            RAM_CFG_ALL_EXT: ext_o = 1'b1;
            RAM_CFG_HI_SWAP: begin
               if (blk_i == 2'd3) ext_o = 1'b1;
               else if (blk_i == 2'd1) blk_o = 2'd3;
            end
            default: ;
         endcase
      end
   end

   assign bank_o = ext_o ? bank_i : '0;

endmodule

// File: rtl/bank_mapper.sv
// Z80-writable memory mapper: ROM enables, upper ROM select and 6128-style
// RAM banking, with a one-update-per-I/O-cycle write FSM.
module bank_mapper
   import bank_mapper_pkg::*;
#(
   parameter int unsigned RAM_BANK_BITS = 3,
   parameter int unsigned ROM_SEL_BITS  = 8
) (
   input  logic                     CLK,
   input  logic                     RESET_n,
   input  logic [15:0]              A,
   input  logic [7:0]               D,
   input  logic                     IORQ_n,
   input  logic                     MREQ_n,
   input  logic                     RD_n,
   input  logic                     WR_n,
   input  logic                     M1_n,
   output logic                     ROMEN_n,
   output logic                     RAMRD_n,
   output logic [ROM_SEL_BITS-1:0]  ROMSEL,
   output logic                     RAM_EXT,
   output logic [RAM_BANK_BITS-1:0] RAM_BANK,
   output logic [1:0]               RAM_BLK
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic                     iow;
   logic                     iow_q;
   logic [7:0]               d_q;
   logic [2:0]               a_q;
   logic [0:0]               state_q,   state_d;
   logic                     lrom_en_q, lrom_en_d;
   logic                     hrom_en_q, hrom_en_d;
   logic [ROM_SEL_BITS-1:0]  romsel_q,  romsel_d;
   ram_cfg_t                 ram_cfg_q, ram_cfg_d;
   logic [RAM_BANK_BITS-1:0] bank_q,    bank_d;
   logic                     ga_sel;
   logic                     rom;
   logic                     mem_rd;
   logic                     unused_addr;

   assign iow         = ~IORQ_n & ~WR_n & M1_n;
   assign unused_addr = ^A[12:0];

   // a_q holds A[15:13]: [2]=A15, [1]=A14, [0]=A13
   assign ga_sel = (a_q[2:1] == 2'b01);

   always_comb begin
      state_d   = state_q;
      lrom_en_d = lrom_en_q;
      hrom_en_d = hrom_en_q;
      romsel_d  = romsel_q;
      ram_cfg_d = ram_cfg_q;
      bank_d    = bank_q;
      unique case (state_q)
         ST_IDLE: begin
            if (iow_q) begin
               state_d = ST_ACTIVE;
               if (ga_sel && d_q[7:6] == GA_FN_ROM) begin
                  lrom_en_d = ~d_q[2];
                  hrom_en_d = ~d_q[3];
               end
               if (ga_sel && d_q[7:6] == GA_FN_RAM) begin
                  ram_cfg_d = d_q[2:0];
                  bank_d    = d_q[3 +: RAM_BANK_BITS];
               end
               if (!a_q[0]) romsel_d = d_q[ROM_SEL_BITS-1:0];
            end
         end
         default: begin
            if (!iow_q) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         iow_q     <= 1'b0;
         d_q       <= '0;
         a_q       <= '0;
         state_q   <= ST_IDLE;
         lrom_en_q <= LROM_EN_RST;
         hrom_en_q <= HROM_EN_RST;
         romsel_q  <= '0;
         ram_cfg_q <= RAM_CFG_RST;
         bank_q    <= '0;
      end else begin
         iow_q     <= iow;
         d_q       <= D;
         a_q       <= A[15:13];
         state_q   <= state_d;
         lrom_en_q <= lrom_en_d;
         hrom_en_q <= hrom_en_d;
         romsel_q  <= romsel_d;
         ram_cfg_q <= ram_cfg_d;
         bank_q    <= bank_d;
      end
   end

   assign rom     = (lrom_en_q & (A[15:14] == 2'b00)) | (hrom_en_q & (A[15:14] == 2'b11));
   assign mem_rd  = ~MREQ_n & ~RD_n;
   assign ROMEN_n = ~(rom & mem_rd);
   assign RAMRD_n = ~(~rom & mem_rd);
   assign ROMSEL  = romsel_q;

   bank_mapper_ram_map #(
      .RAM_BANK_BITS(RAM_BANK_BITS)
   ) u_ram_map (
      .cfg_i  (ram_cfg_q),
      .bank_i (bank_q),
      .blk_i  (A[15:14]),
      .ext_o  (RAM_EXT),
      .bank_o (RAM_BANK),
      .blk_o  (RAM_BLK)
   );

endmodule

// File: tb/tb_bank_mapper.sv
// Randomised self-checking bench for bank_mapper against a register-level
// reference model of the mapper's programming and mapping rules.
`timescale 1ns/1ps
module tb_bank_mapper;

   logic        CLK = 1'b0;
   logic        RESET_n;
   logic [15:0] A;
   logic [7:0]  D;
   logic        IORQ_n, MREQ_n, RD_n, WR_n, M1_n;
   logic        ROMEN_n, RAMRD_n, RAM_EXT;
   logic [7:0]  ROMSEL;
   logic [2:0]  RAM_BANK;
   logic [1:0]  RAM_BLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // reference model state
   bit       m_lrom, m_hrom;
   bit [7:0] m_romsel;
   int       m_cfg, m_bank;

   bank_mapper #(
      .RAM_BANK_BITS(3),
      .ROM_SEL_BITS (8)
   ) dut (
      .CLK(CLK), .RESET_n(RESET_n), .A(A), .D(D), .IORQ_n(IORQ_n),
      .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n), .M1_n(M1_n),
      .ROMEN_n(ROMEN_n), .RAMRD_n(RAMRD_n), .ROMSEL(ROMSEL),
      .RAM_EXT(RAM_EXT), .RAM_BANK(RAM_BANK), .RAM_BLK(RAM_BLK)
   );

   always #31.25 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lrom = 1; m_hrom = 1; m_romsel = 0; m_cfg = 0; m_bank = 0;
   endtask

   task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
      int fn;
      fn = data / 64;
      if (addr[15] == 1'b0 && addr[14] == 1'b1) begin
         if (fn == 2) begin
            m_lrom = !data[2];
            m_hrom = !data[3];
         end
         if (fn == 3) begin
            m_cfg  = data % 8;
            m_bank = (data / 8) % 8;
         end
      end
      if (addr[13] == 1'b0) m_romsel = data;
   endtask

   task automatic check_outputs(input string tag);
      int  b, eblk, ebank;
      bit  rom, rd, ext;
      b   = A / 16384;
      rom = (m_lrom && b == 0) || (m_hrom && b == 3);
      rd  = !MREQ_n && !RD_n;
      ext = 0;
      eblk = b;
      if (m_cfg == 1 && b == 3) ext = 1;
      else if (m_cfg == 2) ext = 1;
      else if (m_cfg == 3 && b == 3) ext = 1;
      else if (m_cfg == 3 && b == 1) eblk = 3;
      else if (m_cfg >= 4 && b == 1) begin
         ext  = 1;
         eblk = m_cfg - 4;
      end
      ebank = ext ? m_bank : 0;
      check_eq({tag, ".romen_n"}, 32'(ROMEN_n), 32'(!(rom && rd)));
      check_eq({tag, ".ramrd_n"}, 32'(RAMRD_n), 32'(!(!rom && rd)));
      check_eq({tag, ".ram_ext"}, 32'(RAM_EXT), 32'(ext));
      check_eq({tag, ".ram_bank"}, 32'(RAM_BANK), 32'(ebank));
      check_eq({tag, ".ram_blk"}, 32'(RAM_BLK), 32'(eblk));
      check_eq({tag, ".romsel"}, 32'(ROMSEL), 32'(m_romsel));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mem_access(input logic [15:0] addr, input logic mreq_n, input logic rd_n, input string tag);
      A = addr; MREQ_n = mreq_n; RD_n = rd_n; WR_n = 1; IORQ_n = 1; M1_n = 1;
      @(negedge CLK);
      check_outputs(tag);
      MREQ_n = 1; RD_n = 1;
      tick();
   endtask

   task automatic io_out(input logic [15:0] addr, input logic [7:0] data, input int unsigned len,
                         input logic [7:0] data_late, input logic m1_n);
      A = addr; D = data; IORQ_n = 0; WR_n = 0; M1_n = m1_n; MREQ_n = 1; RD_n = 1;
      tick();
      D = data_late;
      repeat (len - 1) tick();
      IORQ_n = 1; WR_n = 1; M1_n = 1;
      tick();
      tick();
      if (m1_n) model_write(addr, data);
   endtask

   initial begin
      A = '0; D = '0; IORQ_n = 1; MREQ_n = 1; RD_n = 1; WR_n = 1; M1_n = 1;
      RESET_n = 0;
      model_reset();
      repeat (3) tick();
      RESET_n = 1;
      tick();

      // reset state
      mem_access(16'h0000, 0, 0, "rst_lo");
      mem_access(16'h8000, 0, 0, "rst_b2");
      mem_access(16'hC000, 0, 0, "rst_hi");

      // disable both ROMs
      io_out(16'h7F00, 8'h8C, 1, 8'h8C, 1);
      mem_access(16'hC000, 0, 0, "romoff_hi");
      mem_access(16'h0000, 0, 0, "romoff_lo");

      // RAM banking configs
      io_out(16'h7F00, 8'hC4, 2, 8'hC4, 1);
      mem_access(16'h4000, 0, 0, "cfg4");
      io_out(16'h7F00, 8'hC7, 1, 8'hC7, 1);
      mem_access(16'h4000, 0, 0, "cfg7");
      io_out(16'h7F00, 8'hFA, 1, 8'hFA, 1);
      mem_access(16'hC000, 0, 1, "cfg2_b7");
      io_out(16'h7F00, 8'hC3, 1, 8'hC3, 1);
      mem_access(16'h4000, 0, 0, "cfg3_b1");
      mem_access(16'hC000, 1, 0, "cfg3_b3");

      // upper ROM select
      io_out(16'hDF00, 8'h07, 1, 8'h07, 1);
      mem_access(16'h2000, 0, 0, "romsel7");

      // long strobe: only the first sampled value lands, one cycle after iow_q
      A = 16'hDF00; D = 8'h33; IORQ_n = 0; WR_n = 0; M1_n = 1;
      tick();
      D = 8'h55;
      @(negedge CLK);
      check_eq("long.before", 32'(ROMSEL), 32'(m_romsel));
      tick();
      model_write(16'hDF00, 8'h33);
      @(negedge CLK);
      check_eq("long.after", 32'(ROMSEL), 32'(m_romsel));
      repeat (38) tick();
      IORQ_n = 1; WR_n = 1;
      tick(); tick();
      mem_access(16'h0000, 0, 0, "long.end");

      // interrupt acknowledge never writes
      io_out(16'h5F00, 8'h8C, 3, 8'h8C, 0);
      mem_access(16'h0000, 0, 0, "inta_wr");
      A = 16'h5F00; D = 8'hC1; IORQ_n = 0; M1_n = 0; WR_n = 1;
      repeat (3) tick();
      IORQ_n = 1; M1_n = 1;
      tick();
      mem_access(16'hC000, 0, 0, "inta_rd");

      // one write hitting both RAM config and ROM select
      io_out(16'h5F00, 8'hC1, 1, 8'hC1, 1);
      mem_access(16'hC000, 0, 0, "dual");

      // reset during an active write, strobe held across release
      A = 16'h7F00; D = 8'hC2; IORQ_n = 0; WR_n = 0; M1_n = 1; MREQ_n = 0; RD_n = 0;
      tick();
      tick();
      model_write(16'h7F00, 8'hC2);
      @(negedge CLK);
      check_outputs("mid.pre");
      tick();
      RESET_n = 0;
      D = 8'h8C;
      model_reset();
      @(negedge CLK);
      check_outputs("mid.in_rst");
      tick();
      RESET_n = 1;
      @(negedge CLK);
      check_outputs("mid.rel");
      tick();
      @(negedge CLK);
      check_outputs("mid.iowq");
      tick();
      model_write(16'h7F00, 8'h8C);
      @(negedge CLK);
      check_outputs("mid.applied");
      IORQ_n = 1; WR_n = 1; MREQ_n = 1; RD_n = 1;
      tick(); tick();

      // randomised writes and reads
      for (int i = 0; i < 150; i++) begin
         logic [15:0] addr;
         logic [7:0]  data, late;
         logic        m1;
         addr = 16'($urandom);
         if ($urandom_range(0, 1) == 0) addr[15:13] = 3'($urandom_range(2, 3));
         data = 8'($urandom);
         if ($urandom_range(0, 2) != 0) data[7] = 1'b1;
         late = 8'($urandom);
         m1   = ($urandom_range(0, 7) != 0);
         io_out(addr, data, $urandom_range(1, 4), late, m1);
         mem_access(16'($urandom), 1'($urandom), 1'($urandom), "rnd_a");
         mem_access(16'($urandom), 0, 0, "rnd_b");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bank_mapper.md
Name: bank_mapper

Overview:
- Next-generation memory mapping block. It replaces the fixed combinational ROM/RAM read steering with internally held, Z80-writable configuration registers.
- Registers held: lower/upper ROM enables, upper ROM slot select, and a 6128-style RAM banking register. The expansion bank count is parametrised.
- Sits between the Z80 bus and the DRAM/ROM chip-select logic. It drives ROMEN_n, RAMRD_n and the physical RAM page for every memory access.

Parameters:
- RAM_BANK_BITS, 3: width of expansion bank field (legal 1..3); expansion size = 2^RAM_BANK_BITS x 64 KB.
- ROM_SEL_BITS, 8: width of upper ROM slot select register (legal 1..8).

Ports:
- CLK  in  1  system clock (16 MHz); all state changes on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- A  in  16  Z80 address bus.
- D  in  8  Z80 data bus (write data).
- IORQ_n  in  1  Z80 I/O request.
- MREQ_n  in  1  Z80 memory request.
- RD_n  in  1  Z80 read strobe.
- WR_n  in  1  Z80 write strobe.
- M1_n  in  1  Z80 M1; low with IORQ_n = interrupt acknowledge.
- ROMEN_n  out  1  ROM output enable, low during ROM reads.
- RAMRD_n  out  1  RAM read enable, low during non-ROM memory reads.
- ROMSEL  out  ROM_SEL_BITS  selected upper ROM slot.
- RAM_EXT  out  1  1 = current access targets expansion RAM.
- RAM_BANK  out  RAM_BANK_BITS  expansion 64 KB bank (valid when RAM_EXT=1).
- RAM_BLK  out  2  16 KB block within selected 64 KB (base or expansion).

Behaviour:
- Reset (async, RESET_n=0):
  - lrom_en=1, hrom_en=1, ROMSEL=0, ram_cfg=0, bank=0, FSM=IDLE.
  - Outputs follow combinationally from these values.
- I/O write strobe:
  - iow = ~IORQ_n & ~WR_n & M1_n, registered every CLK into iow_q.
- FSM IDLE -> ACTIVE when iow_q=1:
  - On this transition (single cycle), capture D and A[15:13] from the registered sample.
  - Apply register updates on the same edge; new values are visible on outputs the following cycle.
- FSM ACTIVE -> IDLE when iow_q=0. No further updates while in ACTIVE. Exactly one update per I/O cycle regardless of strobe length.
- Interrupt acknowledge (M1_n=0) never counts as a write.
- Decode of a captured write (decodes are independent; several may fire on one write, e.g. A=&5Fxx):
  - A15=0 & A14=1 & D[7:6]=10: lrom_en=~D[2], hrom_en=~D[3]. Other bits are ignored.
  - A15=0 & A14=1 & D[7:6]=11: ram_cfg=D[2:0], bank=D[5:3] truncated to RAM_BANK_BITS.
  - A13=0: ROMSEL=D[ROM_SEL_BITS-1:0].
  - A15=0 & A14=1 & D[7:6]=00/01: no effect in this block.
- ROM read steering (combinational):
  - rom = (lrom_en & A[15:14]=00) | (hrom_en & A[15:14]=11).
  - ROMEN_n = ~(rom & ~MREQ_n & ~RD_n).
  - RAMRD_n = ~(~rom & ~MREQ_n & ~RD_n).
  - Writes to ROM regions go to RAM (mapping below applies).
- RAM mapping (combinational, by block b=A[15:14]); "ext k" = RAM_EXT=1, RAM_BANK=bank, RAM_BLK=k:
  - cfg 0: base b for all blocks.
  - cfg 1: b=3 -> ext 3; others base b.
  - cfg 2: all b -> ext b.
  - cfg 3: b=3 -> ext 3; b=1 -> base 3; others base b.
  - cfg 4..7: b=1 -> ext (cfg-4); others base b.
  - Base = RAM_EXT=0, RAM_BANK=0, RAM_BLK as listed.
- Reset mid-write:
  - Registers return to reset values and FSM goes to IDLE.
  - If the strobe is still low after release, it is treated as a new write (iow_q rises from 0).

Decomposition:
- Shared package: I/O decode constants (GA function codes 2'b10/2'b11), RAM config encodings, reset values.
- One sub-module, bank_mapper_ram_map: purely combinational mapping from cfg, bank and A[15:14] to RAM_EXT/RAM_BANK/RAM_BLK.
- Write FSM and registers stay in the top module.

Test Plan:
- Reset -> MREQ_n=RD_n=0, A=&0000 gives ROMEN_n=0, RAMRD_n=1; A=&8000 gives ROMEN_n=1, RAMRD_n=0, RAM_EXT=0, RAM_BLK=2.
- OUT &7F00,&8C (disable both ROMs) -> one cycle after iow_q rises, read A=&C000 gives RAMRD_n=0; read A=&0000 gives ROMEN_n=1.
- OUT &7F00,&C4 then &C7 (RAM_BANK_BITS=3) -> A=&4000 maps to ext bank 0 blk 0, then ext bank 0 blk 3; OUT &7F00,&FA (cfg 2, bank 7) -> A=&C000 maps to RAM_EXT=1, RAM_BANK=7, RAM_BLK=3.
- OUT &DF00,&07 -> ROMSEL=7; a 40-cycle-long WR_n low pulse with D changing mid-strobe latches only the first sampled value.
- IORQ_n=0, M1_n=0, WR_n=1 (INTA) -> no register change; OUT &5F00,&C1 -> ram_cfg=1 and ROMSEL=&C1 both updated.
- Assert RESET_n during an active write, release with strobe still low -> registers first show reset values, then the single new write applies.
